packet_encoder: RTL and testbench

//   Packet framer: buffers a byte-serial payload with its destination address and declared size.

---
 rtl/packet_encoder_pkg.sv | 25 ++
 rtl/packet_buf.sv | 27 ++
 rtl/packet_encoder.sv | 158 +++++++++++++++
 tb/tb_packet_encoder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_encoder_pkg.sv
// Shared types and sizing helpers for the packet framer.
package packet_encoder_pkg;

    localparam int unsigned DATA_W_DEF      = 8;
    localparam int unsigned MAX_PAYLOAD_DEF = 64;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        HDR_DEST,
        HDR_LEN,
        PAYLOAD,
        PARITY
    } state_t;

    // Pointers must hold the value MAX_PAYLOAD itself, hence the +1.
    function automatic int unsigned ptr_w(input int unsigned max_payload);
        return $clog2(max_payload + 1);
    endfunction

    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/packet_buf.sv
// Payload register file: synchronous write port, combinational read port.
module packet_buf
    import packet_encoder_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = MAX_PAYLOAD_DEF,
    localparam int unsigned AW    = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/packet_encoder.sv
// Packet framer: captures dest/size/payload, then emits [dest][len][payload][parity].
// Output registers are loaded from the next state, so each byte appears during its own state.
module packet_encoder
    import packet_encoder_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned MAX_PAYLOAD = MAX_PAYLOAD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] payload_din,
    input  logic              ip_valid,
    input  logic [DATA_W-1:0] destination_addr,
    input  logic [DATA_W-1:0] payload_size,
    output logic [DATA_W-1:0] packet_out,
    output logic              packet_valid
);

    localparam int unsigned   PW       = ptr_w(MAX_PAYLOAD);
    localparam int unsigned   AW       = addr_w(MAX_PAYLOAD);
    localparam logic [PW-1:0] SIZE_MAX = PW'(MAX_PAYLOAD);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] dest_q, dest_d;
    logic [PW-1:0]     size_q, size_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [DATA_W-1:0] parity_q, parity_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              valid_q, valid_d;

    logic              buf_we;
    logic [DATA_W-1:0] buf_rdata;
    logic [31:0]       size_ext;
    logic [PW-1:0]     size_sat;

    assign size_ext = 32'(payload_size);
    assign size_sat = (size_ext > 32'(MAX_PAYLOAD)) ? SIZE_MAX : PW'(size_ext);

    packet_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_PAYLOAD)
    ) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (wptr_q[AW-1:0]),
        .wdata_i (payload_din),
        .raddr_i (rptr_q[AW-1:0]),
        .rdata_o (buf_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            dest_q   <= '0;
            size_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            parity_q <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dest_q   <= dest_d;
            size_q   <= size_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            parity_q <= parity_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dest_d   = dest_q;
        size_d   = size_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        parity_d = parity_q;
        out_d    = '0;
        valid_d  = 1'b0;
        buf_we   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ip_valid) begin
                    dest_d   = destination_addr;
                    size_d   = size_sat;
                    parity_d = destination_addr ^ DATA_W'(size_sat);
                    wptr_d   = '0;
                    rptr_d   = '0;
                    if (size_sat == '0) begin
                        state_d = HDR_DEST;
                        out_d   = destination_addr;
                        valid_d = 1'b1;
                    end else begin
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (ip_valid) begin
                    buf_we   = 1'b1;
                    parity_d = parity_q ^ payload_din;
                    wptr_d   = wptr_q + PW'(1);
                    if (wptr_d == size_q) begin
                        state_d = HDR_DEST;
                        out_d   = dest_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    state_d = HDR_DEST;
                    out_d   = dest_q;
                    valid_d = 1'b1;
                end
            end
            HDR_DEST: begin
                // Swap the declared-size term for the stored length in the running parity.
                parity_d = parity_q ^ DATA_W'(size_q) ^ DATA_W'(wptr_q);
                state_d  = HDR_LEN;
                out_d    = DATA_W'(wptr_q);
                valid_d  = 1'b1;
            end
            HDR_LEN: begin
                valid_d = 1'b1;
                if (wptr_q == '0) begin
                    state_d = PARITY;
                    out_d   = parity_q;
                end else begin
                    state_d = PAYLOAD;
                    out_d   = buf_rdata;
                    rptr_d  = rptr_q + PW'(1);
                end
            end
            PAYLOAD: begin
                valid_d = 1'b1;
                if (rptr_q == wptr_q) begin
                    state_d = PARITY;
                    out_d   = parity_q;
                end else begin
                    out_d  = buf_rdata;
                    rptr_d = rptr_q + PW'(1);
                end
            end
            PARITY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign packet_out   = out_q;
    assign packet_valid = valid_q;

endmodule

// File: tb/tb_packet_encoder.sv
// Scoreboard bench for packet_encoder: expected frames are queued as stimulus is driven.
module tb_packet_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] payload_din;
    logic       ip_valid;
    logic [7:0] destination_addr;
    logic [7:0] payload_size;
    logic [7:0] packet_out;
    logic       packet_valid;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [7:0] exp_q [$];
    logic [7:0] rx_q  [$];
    logic [7:0] tx_q  [$];

    always #5 clk = ~clk;

    packet_encoder #(
        .DATA_W      (8),
        .MAX_PAYLOAD (64)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .payload_din      (payload_din),
        .ip_valid         (ip_valid),
        .destination_addr (destination_addr),
        .payload_size     (payload_size),
        .packet_out       (packet_out),
        .packet_valid     (packet_valid)
    );

    // Drives one packet from tx_q and queues the frame it should produce.
    task automatic send_pkt(input logic [7:0] dest, input logic [7:0] size,
                            input int unsigned n, input bit now);
        int unsigned sat;
        int unsigned len;
        logic [7:0]  p;
        sat = (size > 8'd64) ? 64 : 32'(size);
        len = (n < sat) ? n : sat;
        if (!now) begin
            @(posedge clk); #1;
        end
        ip_valid         = 1'b1;
        destination_addr = dest;
        payload_size     = size;
        payload_din      = 8'hEE;
        p = dest ^ 8'(len);
        exp_q.push_back(dest);
        exp_q.push_back(8'(len));
        for (int unsigned i = 0; i < len; i++) begin
            @(posedge clk); #1;
            payload_din = tx_q[i];
            ip_valid    = 1'b1;
            exp_q.push_back(tx_q[i]);
            p ^= tx_q[i];
        end
        exp_q.push_back(p);
        @(posedge clk); #1;
        ip_valid    = 1'b0;
        payload_din = 8'h00;
    endtask

    // Records one frame into rx_q; returns at the first negedge with packet_valid low.
    task automatic collect(output int unsigned cycles);
        int unsigned w;
        w      = 0;
        cycles = 0;
        rx_q.delete();
        @(negedge clk);
        while (packet_valid !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        while (packet_valid === 1'b1 && cycles < 200) begin
            rx_q.push_back(packet_out);
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        ip_valid         = 1'b1;
        destination_addr = 8'h5A;
        payload_size     = 8'h03;
        payload_din      = 8'h77;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (packet_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b want=0", packet_valid);
        end
        checks++;
        if (packet_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_out got=%02h want=00", packet_out);
        end
        ip_valid = 1'b0;
        rst      = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (packet_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_valid got=%b want=0", packet_valid);
        end
    endtask

    task automatic test_basic();
        int unsigned cyc;
        logic [7:0]  e;
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_pkt(8'hAA, 8'h05, 5, 1'b0);
        collect(cyc);
        checks++;
        if (cyc !== 8) begin
            failures++;
            $display("FAIL basic_cycles got=%0d want=8", cyc);
        end
        checks++;
        e = (rx_q.size() > 7) ? rx_q[7] : 8'hxx;
        if (e !== 8'hBE) begin
            failures++;
            $display("FAIL basic_parity got=%02h want=BE", e);
        end
        foreach (rx_q[i]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (rx_q[i] !== e) begin
                failures++;
                $display("FAIL basic_byte%0d got=%02h want=%02h", i, rx_q[i], e);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int unsigned cyc;
        logic [7:0]  e;
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_pkt(8'hAA, 8'h05, 5, 1'b0);
        collect(cyc);
        exp_q.delete();
        // Start the second packet in the very first IDLE cycle after PARITY.
        tx_q = '{8'h66, 8'h77, 8'h88, 8'h99, 8'h55, 8'h56};
        send_pkt(8'hBB, 8'h06, 6, 1'b1);
        collect(cyc);
        checks++;
        if (cyc !== 9) begin
            failures++;
            $display("FAIL b2b_cycles got=%0d want=9", cyc);
        end
        checks++;
        e = (rx_q.size() > 8) ? rx_q[8] : 8'hxx;
        if (e !== 8'hBE) begin
            failures++;
            $display("FAIL b2b_parity got=%02h want=BE", e);
        end
        foreach (rx_q[i]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (rx_q[i] !== e) begin
                failures++;
                $display("FAIL b2b_byte%0d got=%02h want=%02h", i, rx_q[i], e);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_zero_size();
        int unsigned cyc;
        logic [7:0]  e;
        tx_q.delete();
        send_pkt(8'hCC, 8'h00, 0, 1'b0);
        collect(cyc);
        checks++;
        if (cyc !== 3) begin
            failures++;
            $display("FAIL zero_cycles got=%0d want=3", cyc);
        end
        foreach (rx_q[i]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (rx_q[i] !== e) begin
                failures++;
                $display("FAIL zero_byte%0d got=%02h want=%02h", i, rx_q[i], e);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_early_end();
        int unsigned cyc;
        logic [7:0]  e;
        tx_q = '{8'h01, 8'h02, 8'h03};
        send_pkt(8'h10, 8'h05, 3, 1'b0);
        collect(cyc);
        checks++;
        if (cyc !== 6) begin
            failures++;
            $display("FAIL early_cycles got=%0d want=6", cyc);
        end
        checks++;
        e = (rx_q.size() > 5) ? rx_q[5] : 8'hxx;
        if (e !== 8'h13) begin
            failures++;
            $display("FAIL early_parity got=%02h want=13", e);
        end
        foreach (rx_q[i]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (rx_q[i] !== e) begin
                failures++;
                $display("FAIL early_byte%0d got=%02h want=%02h", i, rx_q[i], e);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_oversize();
        int unsigned cyc;
        logic [7:0]  e;
        tx_q.delete();
        for (int i = 0; i < 64; i++) tx_q.push_back(8'($urandom));
        send_pkt(8'h3C, 8'hFF, 64, 1'b0);
        collect(cyc);
        checks++;
        if (cyc !== 67) begin
            failures++;
            $display("FAIL over_cycles got=%0d want=67", cyc);
        end
        checks++;
        e = (rx_q.size() > 1) ? rx_q[1] : 8'hxx;
        if (e !== 8'h40) begin
            failures++;
            $display("FAIL over_len got=%02h want=40", e);
        end
        foreach (rx_q[i]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (rx_q[i] !== e) begin
                failures++;
                $display("FAIL over_byte%0d got=%02h want=%02h", i, rx_q[i], e);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        int unsigned cyc;
        int unsigned w;
        logic [7:0]  e;
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_pkt(8'hAA, 8'h05, 5, 1'b0);
        w = 0;
        @(negedge clk);
        while (packet_valid !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (packet_valid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_prevalid got=%b want=1", packet_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (packet_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_valid got=%b want=0", packet_valid);
        end
        checks++;
        if (packet_out !== 8'h00) begin
            failures++;
            $display("FAIL midrst_out got=%02h want=00", packet_out);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tx_q = '{8'h66, 8'h77, 8'h88, 8'h99, 8'h55, 8'h56};
        send_pkt(8'hBB, 8'h06, 6, 1'b0);
        collect(cyc);
        checks++;
        if (cyc !== 9) begin
            failures++;
            $display("FAIL midrst_cycles got=%0d want=9", cyc);
        end
        foreach (rx_q[i]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (rx_q[i] !== e) begin
                failures++;
                $display("FAIL midrst_byte%0d got=%02h want=%02h", i, rx_q[i], e);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        rst              = 1'b1;
        ip_valid         = 1'b0;
        payload_din      = 8'h00;
        destination_addr = 8'h00;
        payload_size     = 8'h00;
        test_reset();
        test_basic();
        test_back_to_back();
        test_zero_size();
        test_early_end();
        test_oversize();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
